// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and codes for the RV32I pipeline controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   typedef enum logic [0:0] {
      ST_RUN        = 1'b0,
      ST_REDIR_WAIT = 1'b1
   } state_t;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_unit
//  Description : EX-stage bypass select for one source operand.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
   import pipe_pkg::*;
#(
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0] ex_rs,
   input  logic [RA_W-1:0] mem_rd,
   input  logic            mem_regwrite,
   input  logic [RA_W-1:0] wb_rd,
   input  logic            wb_regwrite,
   output logic [1:0]      fwd
);

   logic w_mem_hit;
   logic w_wb_hit;

   // x0 is never a real producer, so it must not bypass
   assign w_mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs);
   assign w_wb_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_rs);

   assign fwd = w_mem_hit ? FWD_MEM : (w_wb_hit ? FWD_WB : FWD_REG);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Hazard/sequencing controller: enables, flushes, forwarding,
//                PC redirect with fetch-stall hold, and perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int RA_W  = 5,
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [RA_W-1:0]  ex_rs1,
   input  logic [RA_W-1:0]  ex_rs2,
   input  logic [RA_W-1:0]  ex_rd,
   input  logic             ex_memread,
   input  logic [RA_W-1:0]  mem_rd,
   input  logic [RA_W-1:0]  wb_rd,
   input  logic             mem_regwrite,
   input  logic             wb_regwrite,
   input  logic             ex_redirect,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             icache_stall,
   input  logic             dcache_stall,
   output logic             pc_en,
   output logic             pc_sel,
   output logic [XLEN-1:0]  pc_tgt,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             redir_pend,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [XLEN-1:0]  r_tgt_q;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   state_t w_next_state;
   logic   w_lu;
   logic   w_load_tgt;
   logic   w_flush_inc;
   logic   w_pc_en, w_pc_sel, w_ifid_en, w_ifid_flush;
   logic   w_idex_en, w_idex_flush, w_exmem_en, w_memwb_en;

   fwd_unit #(.RA_W(RA_W)) u_fwd_a (
      .ex_rs        (ex_rs1),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .fwd          (fwd_a)
   );

   fwd_unit #(.RA_W(RA_W)) u_fwd_b (
      .ex_rs        (ex_rs2),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .fwd          (fwd_b)
   );

   assign w_lu = ex_memread && (ex_rd != '0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      w_next_state = r_state;
      w_load_tgt   = 1'b0;
      w_flush_inc  = 1'b0;
      w_pc_en      = 1'b1;
      w_pc_sel     = 1'b0;
      w_ifid_en    = 1'b1;
      w_ifid_flush = 1'b0;
      w_idex_en    = 1'b1;
      w_idex_flush = 1'b0;
      w_exmem_en   = 1'b1;
      w_memwb_en   = 1'b1;
      case (r_state)
         ST_RUN: begin
            if (dcache_stall) begin
               {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = '0;
            end else if (ex_redirect && !icache_stall) begin
               w_pc_sel     = 1'b1;
               w_ifid_flush = 1'b1;
               w_idex_flush = 1'b1;
               w_flush_inc  = 1'b1;
            end else if (ex_redirect) begin
               // Fetch can't take the target yet: remember it and wait
               w_pc_en      = 1'b0;
               w_ifid_en    = 1'b0;
               w_idex_flush = 1'b1;
               w_flush_inc  = 1'b1;
               w_load_tgt   = 1'b1;
               w_next_state = ST_REDIR_WAIT;
            end else if (w_lu || icache_stall) begin
               w_pc_en      = 1'b0;
               w_ifid_en    = 1'b0;
               w_idex_flush = 1'b1;
            end
         end
         default: begin
            // ID still holds a wrong-path instruction until the redirect lands
            w_idex_flush = 1'b1;
            if (dcache_stall) begin
               {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = '0;
            end else if (icache_stall) begin
               w_pc_en   = 1'b0;
               w_ifid_en = 1'b0;
            end else begin
               w_pc_sel     = 1'b1;
               w_ifid_flush = 1'b1;
               w_next_state = ST_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_tgt_q     <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_load_tgt)  r_tgt_q     <= ex_target;
         if (!w_pc_en)    r_stall_cnt <= r_stall_cnt + c_one;
         if (w_flush_inc) r_flush_cnt <= r_flush_cnt + c_one;
      end
   end

   assign pc_en      = w_pc_en;
   assign pc_sel     = w_pc_sel;
   assign pc_tgt     = (r_state == ST_REDIR_WAIT) ? r_tgt_q : ex_target;
   assign ifid_en    = w_ifid_en;
   assign ifid_flush = w_ifid_flush;
   assign idex_en    = w_idex_en;
   assign idex_flush = w_idex_flush;
   assign exmem_en   = w_exmem_en;
   assign memwb_en   = w_memwb_en;
   assign redir_pend = (r_state == ST_REDIR_WAIT);
   assign stall_cnt  = r_stall_cnt;
   assign flush_cnt  = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed self-checking bench for pipe_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

   localparam int RA_W  = 5;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [RA_W-1:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic             id_use_rs1, id_use_rs2, ex_memread, mem_regwrite, wb_regwrite;
   logic             ex_redirect, icache_stall, dcache_stall;
   logic [XLEN-1:0]  ex_target;
   logic             pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush;
   logic             exmem_en, memwb_en, redir_pend;
   logic [XLEN-1:0]  pc_tgt;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks   = 0;
   int failures = 0;

   // {pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
   logic [7:0] w_ctl;
   assign w_ctl = {pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

   always #5 clk = ~clk;

   pipe_ctrl #(.RA_W(RA_W), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
      .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
      .ex_redirect(ex_redirect), .ex_target(ex_target),
      .icache_stall(icache_stall), .dcache_stall(dcache_stall),
      .pc_en(pc_en), .pc_sel(pc_sel), .pc_tgt(pc_tgt),
      .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
      .exmem_en(exmem_en), .memwb_en(memwb_en), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .redir_pend(redir_pend), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic quiet();
      id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_memread = 1'b0;
      mem_rd = '0; wb_rd = '0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
      ex_redirect = 1'b0; ex_target = '0; icache_stall = 1'b0; dcache_stall = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      quiet();
      rst_n = 1'b0;
      #12;
      chk("reset_ctl", w_ctl, 8'hAB);
      chk("reset_fwd", {fwd_a, fwd_b}, 4'h0);
      chk("reset_cnt", {stall_cnt, flush_cnt}, 8'h00);
      chk("reset_pend", redir_pend, 1'b0);
      rst_n = 1'b1;
      tick();

      // T1 load-use on rs1
      ex_memread = 1'b1; ex_rd = 5'd5;
      id_rs1 = 5'd5; id_rs2 = 5'd1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
      #1 chk("t1_lu_ctl", w_ctl, 8'h0F);
      tick(); quiet();
      #1 chk("t1_stall_cnt", stall_cnt, 4'd1);
      chk("t1_after_ctl", w_ctl, 8'hAB);

      // T2 load to x0, and a match on an unused operand: no stall
      ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
      #1 chk("t2_x0_ctl", w_ctl, 8'hAB);
      ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
      #1 chk("t2_unused_ctl", w_ctl, 8'hAB);
      id_rs1 = 5'd0; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
      #1 chk("t2_rs2_lu_ctl", w_ctl, 8'h0F);
      id_use_rs2 = 1'b0;
      tick(); quiet();
      #1 chk("t2_stall_cnt", stall_cnt, 4'd1);

      // T3 forwarding priority
      mem_rd = 5'd3; wb_rd = 5'd3; ex_rs1 = 5'd3; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
      #1 chk("t3_fwd_mem", {fwd_a, fwd_b}, {2'b01, 2'b00});
      mem_regwrite = 1'b0;
      #1 chk("t3_fwd_wb", fwd_a, 2'b10);
      ex_rs2 = 5'd3;
      #1 chk("t3_fwd_b_wb", fwd_b, 2'b10);
      mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; mem_regwrite = 1'b1;
      #1 chk("t3_fwd_x0", fwd_a, 2'b00);
      quiet();

      // T4 redirect, fetch ready
      ex_redirect = 1'b1; ex_target = 32'h100;
      #1 chk("t4_ctl", w_ctl, 8'hFF);
      chk("t4_tgt", pc_tgt, 32'h100);
      tick(); quiet();
      #1 chk("t4_flush_cnt", flush_cnt, 4'd1);
      chk("t4_after_ctl", w_ctl, 8'hAB);
      chk("t4_pend", redir_pend, 1'b0);

      // T5 redirect while fetch stalled, held 3 more cycles
      ex_redirect = 1'b1; ex_target = 32'h200; icache_stall = 1'b1;
      #1 chk("t5_entry_ctl", w_ctl, 8'h0F);
      tick();
      ex_redirect = 1'b0; ex_target = 32'h999;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
            ex_redirect = 1'b1;
         end
         #1 chk("t5_wait_pend", redir_pend, 1'b1);
         chk("t5_wait_ctl", w_ctl, 8'h0F);
         chk("t5_wait_tgt", pc_tgt, 32'h200);
         tick();
         ex_memread = 1'b0; ex_redirect = 1'b0;
      end
      icache_stall = 1'b0;
      #1 chk("t5_exit_ctl", w_ctl, 8'hFF);
      chk("t5_exit_tgt", pc_tgt, 32'h200);
      tick(); quiet();
      #1 chk("t5_pend_clr", redir_pend, 1'b0);
      chk("t5_cnts", {stall_cnt, flush_cnt}, {4'd5, 4'd2});

      // dcache stall in RUN freezes everything, redirect not counted
      dcache_stall = 1'b1; ex_redirect = 1'b1; icache_stall = 1'b1;
      #1 chk("run_dstall_ctl", w_ctl, 8'h00);
      tick();
      #1 chk("run_dstall_cnts", {stall_cnt, flush_cnt, 3'b000, redir_pend}, {4'd6, 4'd2, 4'd0});
      dcache_stall = 1'b0;

      // T6 enter REDIR_WAIT, dcache stall, then reset pulse
      ex_target = 32'h300;
      tick();
      ex_redirect = 1'b0;
      #1 chk("t6_pend", redir_pend, 1'b1);
      chk("t6_cnts", {stall_cnt, flush_cnt}, {4'd7, 4'd3});
      dcache_stall = 1'b1;
      #1 chk("t6_dstall_ctl", w_ctl, 8'h04);
      tick();
      #1 chk("t6_stall_cnt", stall_cnt, 4'd8);
      rst_n = 1'b0;
      #1 chk("t6_rst_pend", redir_pend, 1'b0);
      chk("t6_rst_cnts", {stall_cnt, flush_cnt}, 8'h00);
      quiet();
      tick();
      rst_n = 1'b1;
      #1 chk("t6_post_ctl", w_ctl, 8'hAB);
      tick();

      // stall counter wraps modulo 2^CNT_W
      icache_stall = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      chk("wrap_max", stall_cnt, 4'hF);
      tick();
      chk("wrap_zero", stall_cnt, 4'h0);
      quiet();
      tick();
      chk("wrap_hold", stall_cnt, 4'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
